// File: rtl/slot_reel_engine.sv
// slot_reel_engine: spins three reels while the FSM runs, then stops them
// one at a time and reports the result. Define SLOT_PAIR_WIN_EN for pair_flag.
module slot_reel_engine #(
   parameter int NUM_SYMBOLS = 8,
   parameter int SPIN_DIV    = 4,
   parameter int STOP_GAP    = 16,
   localparam int W          = $clog2(NUM_SYMBOLS)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   state,
   output logic [W-1:0] reel0,
   output logic [W-1:0] reel1,
   output logic [W-1:0] reel2,
   output logic         reels_stopped,
   output logic         win_flag,
   output logic         pair_flag
);

   localparam int PW = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
   localparam int GW = $clog2(2 * STOP_GAP + 2);
   localparam int SW = W + 3;

   localparam logic [1:0] S_SET  = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_STOP = 2'b10;
   localparam logic [1:0] S_WIN  = 2'b11;

   typedef enum logic [1:0] {
      E_IDLE,
      E_SPIN,
      E_STOP_SEQ,
      E_DONE
   } eng_e;

   eng_e          eng_q;
   logic [PW-1:0] pre_q, pre_d;
   logic [GW-1:0] gap_q;
   logic [2:0]    frozen_q, frz;
   logic [W-1:0]  r0_q, r1_q, r2_q;
   logic [W-1:0]  r0_d, r1_d, r2_d;
   logic          stopped_q, win_q;
   logic          tick, done_now, clr_flags, all_eq;

   function automatic logic [W-1:0] step(input logic [W-1:0] r, input int inc);
      logic [SW-1:0] s;
      s = SW'(r) + SW'(inc);
      return W'(s % SW'(NUM_SYMBOLS));
   endfunction

   // Prescaler tick, freeze mask for this cycle and next reel values
   always_comb begin
      tick  = (pre_q == PW'(SPIN_DIV - 1));
      pre_d = tick ? '0 : pre_q + PW'(1);
      frz   = frozen_q;
      if (eng_q == E_SPIN && state == S_STOP)
         frz[0] = 1'b1;
      if (eng_q == E_STOP_SEQ && state == S_STOP) begin
         if (gap_q >= GW'(STOP_GAP))     frz[1] = 1'b1;
         if (gap_q >= GW'(2 * STOP_GAP)) frz[2] = 1'b1;
      end
      r0_d = (tick && !frz[0]) ? step(r0_q, 1) : r0_q;
      r1_d = (tick && !frz[1]) ? step(r1_q, 3) : r1_q;
      r2_d = (tick && !frz[2]) ? step(r2_q, 5) : r2_q;
      done_now  = (eng_q == E_STOP_SEQ) && (state == S_STOP) && frz[2];
      clr_flags = (state == S_SET) ||
                  (state == S_RUN &&
                   (eng_q == E_STOP_SEQ || eng_q == E_DONE));
      all_eq    = (r0_q == r1_q) && (r1_q == r2_q);
   end

   // Engine sequencing: idle, spin, staggered stop, hold result
   always_ff @(posedge clk) begin
      if (rst) begin
         eng_q    <= E_IDLE;
         pre_q    <= '0;
         gap_q    <= '0;
         frozen_q <= '0;
         r0_q     <= '0;
         r1_q     <= '0;
         r2_q     <= '0;
      end else begin
         unique case (eng_q)
            E_IDLE: begin
               if (state == S_RUN) begin
                  eng_q    <= E_SPIN;
                  pre_q    <= '0;
                  gap_q    <= '0;
                  frozen_q <= '0;
               end
            end
            E_SPIN, E_STOP_SEQ: begin
               if (state == S_SET) begin
                  eng_q    <= E_IDLE;
                  pre_q    <= '0;
                  gap_q    <= '0;
                  frozen_q <= '0;
               end else if (state == S_RUN && eng_q == E_STOP_SEQ) begin
                  eng_q    <= E_SPIN;
                  pre_q    <= '0;
                  gap_q    <= '0;
                  frozen_q <= '0;
               end else if (state != S_WIN) begin
                  pre_q    <= pre_d;
                  frozen_q <= frz;
                  r0_q     <= r0_d;
                  r1_q     <= r1_d;
                  r2_q     <= r2_d;
                  if (eng_q == E_SPIN) begin
                     if (state == S_STOP) begin
                        eng_q <= E_STOP_SEQ;
                        gap_q <= GW'(1);
                     end
                  end else begin
                     gap_q <= gap_q + GW'(1);
                     if (frz[2]) eng_q <= E_DONE;
                  end
               end
            end
            E_DONE: begin
               if (state == S_SET) begin
                  eng_q    <= E_IDLE;
                  pre_q    <= '0;
                  gap_q    <= '0;
                  frozen_q <= '0;
               end else if (state == S_RUN) begin
                  eng_q    <= E_SPIN;
                  pre_q    <= '0;
                  gap_q    <= '0;
                  frozen_q <= '0;
               end
            end
            default: eng_q <= E_IDLE;
         endcase
      end
   end

   // Result flags: latched when the last reel freezes, cleared on SET or restart
   always_ff @(posedge clk) begin
      if (rst || clr_flags) begin
         stopped_q <= 1'b0;
         win_q     <= 1'b0;
      end else if (done_now) begin
         stopped_q <= 1'b1;
         win_q     <= all_eq;
      end
   end

`ifdef SLOT_PAIR_WIN_EN
   logic pair_q, two_eq;

   // Exactly two reels matching, latched alongside win_flag
   always_comb begin
      two_eq = ((r0_q == r1_q) || (r1_q == r2_q) || (r0_q == r2_q)) && !all_eq;
   end

   // Pair flag follows the same latch and clear timing as win_flag
   always_ff @(posedge clk) begin
      if (rst || clr_flags)
         pair_q <= 1'b0;
      else if (done_now)
         pair_q <= two_eq;
   end

   assign pair_flag = pair_q;
`else
   assign pair_flag = 1'b0;
`endif

   assign reel0         = r0_q;
   assign reel1         = r1_q;
   assign reel2         = r2_q;
   assign reels_stopped = stopped_q;
   assign win_flag      = win_q;

endmodule

// File: tb/tb_slot_reel_engine.sv
// tb_slot_reel_engine: scenario tasks plus randomized segments against a
// tick-count / stop-age reference model of the reel engine.
module tb_slot_reel_engine;

   localparam int N   = 8;
   localparam int DIV = 4;
   localparam int G   = 16;

   localparam logic [1:0] SET = 2'b00;
   localparam logic [1:0] RUN = 2'b01;
   localparam logic [1:0] STP = 2'b10;
   localparam logic [1:0] WN  = 2'b11;

   localparam int M_IDLE = 0;
   localparam int M_SPIN = 1;
   localparam int M_SEQ  = 2;
   localparam int M_DONE = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] state = SET;
   logic [2:0] reel0, reel1, reel2;
   logic       reels_stopped, win_flag, pair_flag;

   int total  = 0;
   int passed = 0;

   int m_r[3];
   int m_mode, m_phase, m_age;
   bit m_stop, m_win, m_pair;
   int STEP[3] = '{1, 3, 5};

   slot_reel_engine dut (
      .clk           (clk),
      .rst           (rst),
      .state         (state),
      .reel0         (reel0),
      .reel1         (reel1),
      .reel2         (reel2),
      .reels_stopped (reels_stopped),
      .win_flag      (win_flag),
      .pair_flag     (pair_flag)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] mreels();
      return {3'(m_r[0]), 3'(m_r[1]), 3'(m_r[2])};
   endfunction

   function automatic logic [2:0] mflags();
      return {m_stop, m_win, m_pair};
   endfunction

   function automatic void model_clear();
      m_stop = 0;
      m_win  = 0;
      m_pair = 0;
   endfunction

   function automatic void model(input logic [1:0] st);
      bit tk;
      int eqs;
      if (rst) begin
         for (int i = 0; i < 3; i++) m_r[i] = 0;
         m_mode = M_IDLE; m_phase = 0; m_age = 0;
         model_clear();
         return;
      end
      case (m_mode)
         M_IDLE: begin
            if (st == RUN) begin m_mode = M_SPIN; m_phase = 0; end
         end
         M_SPIN, M_SEQ: begin
            if (st == SET) begin
               m_mode = M_IDLE; model_clear();
            end else if (st == RUN && m_mode == M_SEQ) begin
               m_mode = M_SPIN; m_phase = 0; model_clear();
            end else if (st != WN) begin
               tk = (m_phase % DIV) == DIV - 1;
               if (m_mode == M_SPIN && st == STP) begin
                  m_mode = M_SEQ; m_age = 0;
               end
               for (int i = 0; i < 3; i++)
                  if (tk && !(m_mode == M_SEQ && m_age >= i * G))
                     m_r[i] = (m_r[i] + STEP[i]) % N;
               m_phase++;
               if (m_mode == M_SEQ) begin
                  if (m_age >= 2 * G) begin
                     m_mode = M_DONE;
                     m_stop = 1;
                     m_win  = (m_r[0] == m_r[1]) && (m_r[1] == m_r[2]);
                     eqs = int'(m_r[0] == m_r[1]) + int'(m_r[1] == m_r[2])
                         + int'(m_r[0] == m_r[2]);
`ifdef SLOT_PAIR_WIN_EN
                     m_pair = (eqs == 1);
`else
                     m_pair = 0;
`endif
                  end
                  m_age++;
               end
            end
         end
         default: begin
            if (st == SET) begin
               m_mode = M_IDLE; model_clear();
            end else if (st == RUN) begin
               m_mode = M_SPIN; m_phase = 0; model_clear();
            end
         end
      endcase
   endfunction

   task automatic cyc(input logic [1:0] st);
      state = st;
      @(posedge clk);
      model(st);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(RUN);
      cyc(RUN);
      total++;
      if ({reel0, reel1, reel2} !== 9'd0)
         $display("FAIL reset_reels: got %0d,%0d,%0d want 0,0,0", reel0, reel1, reel2);
      else passed++;
      total++;
      if ({reels_stopped, win_flag, pair_flag} !== 3'b000)
         $display("FAIL reset_flags: got %b want 000", {reels_stopped, win_flag, pair_flag});
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_spin_rate();
      repeat (17) cyc(RUN);
      total++;
      if ({reel0, reel1, reel2} !== {3'd4, 3'd4, 3'd4})
         $display("FAIL spin_4ticks: got %0d,%0d,%0d want 4,4,4", reel0, reel1, reel2);
      else passed++;
      repeat (16) cyc(RUN);
      total++;
      if ({reel0, reel1, reel2} !== 9'd0)
         $display("FAIL spin_8ticks: got %0d,%0d,%0d want 0,0,0", reel0, reel1, reel2);
      else passed++;
      total++;
      if ({reels_stopped, win_flag, pair_flag} !== 3'b000)
         $display("FAIL spin_flags: got %b want 000", {reels_stopped, win_flag, pair_flag});
      else passed++;
      cyc(SET);
   endtask

   task automatic test_win_hold();
      repeat (25) cyc(RUN);
      total++;
      if ({reel0, reel1, reel2} !== {3'd6, 3'd2, 3'd6})
         $display("FAIL win_prestop: got %0d,%0d,%0d want 6,2,6", reel0, reel1, reel2);
      else passed++;
      repeat (32) cyc(STP);
      total++;
      if (reels_stopped !== 1'b0)
         $display("FAIL win_early_stop: got %b want 0 at T+32", reels_stopped);
      else passed++;
      cyc(STP);
      total++;
      if ({reels_stopped, win_flag, pair_flag} !== 3'b110)
         $display("FAIL win_flags: got %b want 110 at T+33", {reels_stopped, win_flag, pair_flag});
      else passed++;
      total++;
      if ({reel0, reel1, reel2} !== {3'd6, 3'd6, 3'd6})
         $display("FAIL win_reels: got %0d,%0d,%0d want 6,6,6", reel0, reel1, reel2);
      else passed++;
      for (int i = 0; i < 20; i++) begin
         cyc(WN);
         total++;
         if ({reel0, reel1, reel2, reels_stopped, win_flag} !== {9'o666, 2'b11})
            $display("FAIL win_hold[%0d]: got %0d,%0d,%0d s=%b w=%b want 6,6,6 s=1 w=1",
                     i, reel0, reel1, reel2, reels_stopped, win_flag);
         else passed++;
      end
      cyc(SET);
      total++;
      if ({reel0, reel1, reel2, reels_stopped, win_flag} !== {9'o666, 2'b00})
         $display("FAIL win_clear: got %0d,%0d,%0d s=%b w=%b want 6,6,6 s=0 w=0",
                  reel0, reel1, reel2, reels_stopped, win_flag);
      else passed++;
   endtask

   task automatic test_loss_pair();
      logic exp_pair;
      rst = 1'b1; cyc(SET); cyc(SET); rst = 1'b0;
      repeat (5) cyc(RUN);
      repeat (33) cyc(STP);
      total++;
      if ({reel0, reel1, reel2} !== {3'd1, 3'd7, 3'd5})
         $display("FAIL loss_reels: got %0d,%0d,%0d want 1,7,5", reel0, reel1, reel2);
      else passed++;
      total++;
      if ({reels_stopped, win_flag, pair_flag} !== 3'b100)
         $display("FAIL loss_flags: got %b want 100", {reels_stopped, win_flag, pair_flag});
      else passed++;
      rst = 1'b1; cyc(SET); cyc(SET); rst = 1'b0;
      cyc(RUN);
      repeat (33) cyc(STP);
`ifdef SLOT_PAIR_WIN_EN
      exp_pair = 1'b1;
`else
      exp_pair = 1'b0;
`endif
      total++;
      if ({reel0, reel1, reel2} !== {3'd0, 3'd4, 3'd0})
         $display("FAIL pair_reels: got %0d,%0d,%0d want 0,4,0", reel0, reel1, reel2);
      else passed++;
      total++;
      if ({reels_stopped, win_flag, pair_flag} !== {2'b10, exp_pair})
         $display("FAIL pair_flags: got %b want %b",
                  {reels_stopped, win_flag, pair_flag}, {2'b10, exp_pair});
      else passed++;
   endtask

   task automatic test_abort();
      cyc(SET);
      repeat (9) cyc(RUN);
      repeat (10) cyc(STP);
      cyc(SET);
      total++;
      if ({reel0, reel1, reel2, reels_stopped, win_flag, pair_flag} !==
          {3'd2, 3'd0, 3'd4, 3'b000})
         $display("FAIL abort_set: got %0d,%0d,%0d f=%b want 2,0,4 f=000",
                  reel0, reel1, reel2, {reels_stopped, win_flag, pair_flag});
      else passed++;
      repeat (5) cyc(SET);
      total++;
      if ({reel0, reel1, reel2} !== {3'd2, 3'd0, 3'd4})
         $display("FAIL abort_hold: got %0d,%0d,%0d want 2,0,4", reel0, reel1, reel2);
      else passed++;
      repeat (5) cyc(RUN);
      total++;
      if ({reel0, reel1, reel2} !== {3'd3, 3'd3, 3'd1})
         $display("FAIL abort_restart: got %0d,%0d,%0d want 3,3,1", reel0, reel1, reel2);
      else passed++;
      repeat (40) cyc(STP);
      cyc(RUN);
      total++;
      if ({reels_stopped, win_flag, pair_flag} !== 3'b000)
         $display("FAIL abort_run_clear: got %b want 000", {reels_stopped, win_flag, pair_flag});
      else passed++;
      total++;
      if ({reel0, reel1, reel2} !== mreels())
         $display("FAIL abort_run_reels: got %0d,%0d,%0d want %0d,%0d,%0d",
                  reel0, reel1, reel2, m_r[0], m_r[1], m_r[2]);
      else passed++;
   endtask

   task automatic test_random();
      logic [1:0] st;
      int len;
      for (int it = 0; it < 40; it++) begin
         st  = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 40);
         if (st == WN && (m_mode == M_SPIN || m_mode == M_SEQ)) st = STP;
         repeat (len) cyc(st);
         total++;
         if ({reel0, reel1, reel2} !== mreels())
            $display("FAIL rand_reels[%0d]: got %0d,%0d,%0d want %0d,%0d,%0d",
                     it, reel0, reel1, reel2, m_r[0], m_r[1], m_r[2]);
         else passed++;
         total++;
         if ({reels_stopped, win_flag, pair_flag} !== mflags())
            $display("FAIL rand_flags[%0d]: got %b want %b",
                     it, {reels_stopped, win_flag, pair_flag}, mflags());
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_spin_rate();
      test_win_hold();
      test_loss_pair();
      test_abort();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
